mem_readback_ctrl: RTL and testbench

Hardware readback engine for the CPU's external memory access port, the read-side counterpart to the word-by-word external write load of IMEM/DMEM. After a run (e.g. on the STOP instruction), it walks a contiguous word range through `addr_ext`/`ren_ext`/`rdata_ext`, captures each returned word, and streams it out over a valid/ready interface to a trace/UART/compare sink. Optional running checksum lets the bench or host check a whole memory image with one compare.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/rb_fifo2.sv | 53 +++++
 rtl/mem_readback_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_readback_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU memory-side helpers.
//   rb_state_t     : state encoding of the memory readback engine
//   MEM_WORD_BYTES : bytes per memory word (address stride)
//   DMEM_WORDS     : data memory size in words (largest readback length)
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int MEM_WORD_BYTES = 4;
   localparam int DMEM_WORDS     = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rb_state_t;

endpackage

// File: rtl/rb_fifo2.sv
// -----------------------------------------------------------------------------
// rb_fifo2
// Two-entry FIFO buffering words returned by the memory port before they are
// streamed to the sink. No pass-through: a pushed word is visible at the head
// one cycle after the push edge.
// Ports:
//   clk, arst_n  : clock, asynchronous active-low reset (clears contents)
//   i_push       : write i_push_data this cycle (caller guarantees not full)
//   i_pop        : discard head this cycle (caller guarantees not empty)
//   o_count      : number of stored words, 0..2
//   o_head       : oldest stored word
// -----------------------------------------------------------------------------
module rb_fifo2 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [1:0]        o_count,
   output logic [DATA_W-1:0] o_head
);

   logic [DATA_W-1:0] r_mem [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/mem_readback_ctrl.sv
// -----------------------------------------------------------------------------
// mem_readback_ctrl
// Walks a contiguous word range of the external memory port and streams each
// word out over a valid/ready interface.
// Optional feature macro: MEM_READBACK_CHECKSUM_EN (running rotate/XOR checksum
// of every streamed word; when undefined, checksum is tied to 0).
// Ports:
//   clk, arst_n          : clock, asynchronous active-low reset
//   start                : one-cycle request, sampled only when idle
//   base_addr, num_words : byte address of word 0, word count (clamped)
//   busy, done           : engine active, one-cycle completion pulse
//   addr_ext, ren_ext,
//   wen_ext, rdata_ext   : external memory port (data one cycle after ren)
//   out_data, out_valid,
//   out_ready            : word stream to the sink
//   checksum             : running checksum of streamed words
// -----------------------------------------------------------------------------
module mem_readback_ctrl
   import cpu_pkg::*;
#(
   parameter  int DATA_W    = 32,
   parameter  int ADDR_W    = 32,
   parameter  int MAX_WORDS = DMEM_WORDS,
   localparam int CNT_W     = $clog2(MAX_WORDS) + 1
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_words,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] addr_ext,
   output logic              ren_ext,
   output logic              wen_ext,
   input  logic [DATA_W-1:0] rdata_ext,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] checksum
);

   rb_state_t         r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_remaining;
   logic              r_inflight;

   logic [1:0]        w_count;
   logic [DATA_W-1:0] w_head;
   logic              w_pop;
   logic [2:0]        w_occ;
   logic              w_ren;
   logic              w_last;
   logic              w_accept;
   logic [CNT_W-1:0]  w_num;
   logic [ADDR_W-1:0] w_base;

   assign w_num  = (num_words > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : num_words;
   assign w_base = base_addr & ~ADDR_W'(MEM_WORD_BYTES - 1);

   assign w_accept = (r_state == IDLE) && start;
   assign w_pop    = out_valid && out_ready;

   // Credit: stored words plus the read in flight, less the word leaving this
   // cycle, must leave room for the read issued now.
   assign w_occ = {1'b0, w_count} + {2'b00, r_inflight};
   assign w_ren = (r_state == READ) && (r_remaining != '0) &&
                  (w_occ < (3'd2 + {2'b00, w_pop}));

   // Last handoff: nothing left to read or land, and the only stored word
   // leaves now. done pulses in this very cycle so it lines up with the
   // final handshake even under backpressure.
   assign w_last = (r_state == DRAIN) && !r_inflight && (w_count == 2'd1) && w_pop;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_inflight  <= 1'b0;
      end else begin
         r_inflight <= w_ren;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (w_num != '0) begin
                     r_addr      <= w_base;
                     r_remaining <= w_num;
                     r_state     <= READ;
                  end else begin
                     r_state <= DONE;
                  end
               end
            end
            READ: begin
               if (w_ren) begin
                  r_addr      <= r_addr + ADDR_W'(MEM_WORD_BYTES);
                  r_remaining <= r_remaining - CNT_W'(1);
                  if (r_remaining == CNT_W'(1)) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_last) begin
                  r_state <= IDLE;
               end
            end
            // Only reached for an empty request.
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   rb_fifo2 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .arst_n      (arst_n),
      .i_push      (r_inflight),
      .i_push_data (rdata_ext),
      .i_pop       (w_pop),
      .o_count     (w_count),
      .o_head      (w_head)
   );

   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE) || w_last;
   assign addr_ext  = r_addr;
   assign ren_ext   = w_ren;
   assign wen_ext   = 1'b0;
   assign out_valid = (w_count != 2'd0);
   assign out_data  = w_head;

`ifdef MEM_READBACK_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_checksum <= '0;
      end else if (w_accept) begin
         r_checksum <= '0;
      end else if (w_pop) begin
         r_checksum <= {r_checksum[DATA_W-2:0], r_checksum[DATA_W-1]} ^ out_data;
      end
   end

   assign checksum = r_checksum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_readback_ctrl.sv
module tb_mem_readback_ctrl;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        start;
   logic [31:0] base_addr;
   logic [10:0] num_words;
   logic        busy;
   logic        done;
   logic [31:0] addr_ext;
   logic        ren_ext;
   logic        wen_ext;
   logic [31:0] rdata_ext = 32'h0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] checksum;

   mem_readback_ctrl dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .addr_ext  (addr_ext),
      .ren_ext   (ren_ext),
      .wen_ext   (wen_ext),
      .rdata_ext (rdata_ext),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory model ----------------
   logic [31:0] dmem [0:15];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a < 32'd64) return dmem[a[5:2]];
      return ~a;
   endfunction

   always @(posedge clk) begin
      if (ren_ext) rdata_ext <= mem_rd(addr_ext);
   end

   // ---------------- sink ready pattern ----------------
   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) begin
         case (cyc % 4)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end else begin
         out_ready = 1'b1;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];

   int checks = 0;
   int errors = 0;

   int ren_cnt, valid_cnt, busy_cnt, done_cnt, done_cyc, hs_cnt;
   logic [31:0] done_ck;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      ren_cnt   = 0;
      valid_cnt = 0;
      busy_cnt  = 0;
      done_cnt  = 0;
      done_cyc  = -1;
      hs_cnt    = 0;
      done_ck   = 32'h0;
   endtask

   int          occ = 0;
   logic        infl = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = 32'h0;

   always @(negedge clk) begin
      logic pop;
      exp_t e;
      logic [31:0] ea;
      if (!arst_n) begin
         occ        = 0;
         infl       = 1'b0;
         prev_stall = 1'b0;
      end else begin
         pop = out_valid && out_ready;
         chk("wen_ext_low", {31'b0, wen_ext}, 32'h0);
         chk("valid_vs_occupancy", {31'b0, out_valid}, {31'b0, (occ != 0)});
         if (prev_stall) begin
            chk("stall_valid_held", {31'b0, out_valid}, 32'h1);
            chk("stall_data_stable", out_data, prev_data);
         end
         if (pop) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %h expected none", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e.data);
               if (e.cyc >= 0) chk("out_cycle", cyc, e.cyc);
            end
         end
         if (ren_ext) begin
            ren_cnt++;
            chk("credit_ok", {31'b0, ((occ + int'(infl) - int'(pop)) < 2)}, 32'h1);
            if (addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read: got addr %h expected none", addr_ext);
            end else begin
               ea = addr_q.pop_front();
               chk("addr_ext", addr_ext, ea);
            end
         end
         if (out_valid) valid_cnt++;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_ck  = checksum;
         end
         occ        = occ + int'(infl) - int'(pop);
         infl       = ren_ext;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // ---------------- stimulus ----------------
   int t0;

   task automatic issue(input logic [31:0] base, input int num, input bit timed);
      @(posedge clk);
      #1;
      t0 = cyc;
      for (int i = 0; i < num; i++) begin
         exp_q.push_back('{data: mem_rd(base + 32'(i * 4)), cyc: (timed ? t0 + 3 + i : -1)});
         addr_q.push_back(base + 32'(i * 4));
      end
      start     = 1'b1;
      base_addr = base;
      num_words = 11'(num);
      @(posedge clk);
      #1;
      // later input changes must have no effect
      start     = 1'b0;
      base_addr = 32'hDEADBEE0;
      num_words = 11'd5;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && done_cnt == 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk("done_pulses", done_cnt, 1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
      chk({tag, "_done"}, {31'b0, done}, 32'h0);
      chk({tag, "_addr"}, addr_ext, 32'h0);
      chk({tag, "_ren"}, {31'b0, ren_ext}, 32'h0);
      chk({tag, "_wen"}, {31'b0, wen_ext}, 32'h0);
      chk({tag, "_data"}, out_data, 32'h0);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
      chk({tag, "_cksum"}, checksum, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_ck;
      arst_n    = 1'b0;
      start     = 1'b0;
      base_addr = 32'h0;
      num_words = 11'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) dmem[i] = 32'h100 + 32'(i);
      clear_stats();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #3 arst_n = 1'b1;

      // 1: 8 words, sink always ready, exact cycle timing
      $display("T1: base=0 num=8 ready=1");
      clear_stats();
      issue(32'h0, 8, 1'b1);
      wait_done(100);
      chk("t1_done_cycle", done_cyc, t0 + 10);
      chk("t1_ren_count", ren_cnt, 8);
      chk("t1_busy_cycles", busy_cnt, 10);
      chk("t1_left_exp", exp_q.size(), 0);

      // 2: same dump with backpressure
      $display("T2: base=0 num=8 ready toggling 1,0,0,1");
      clear_stats();
      rdy_mode = 1;
      issue(32'h0, 8, 1'b0);
      wait_done(200);
      chk("t2_ren_count", ren_cnt, 8);
      chk("t2_words", hs_cnt, 8);
      chk("t2_left_exp", exp_q.size(), 0);
      rdy_mode = 0;
      repeat (2) @(posedge clk);

      // 3: empty request
      $display("T3: num=0");
      clear_stats();
      issue(32'h0, 0, 1'b1);
      wait_done(20);
      chk("t3_done_cycle", done_cyc, t0 + 1);
      chk("t3_ren_count", ren_cnt, 0);
      chk("t3_valid_cycles", valid_cnt, 0);
      chk("t3_busy_cycles", busy_cnt, 1);

      // 4: address wrap
      $display("T4: base=FFFFFFF8 num=3");
      clear_stats();
      issue(32'hFFFF_FFF8, 3, 1'b1);
      wait_done(50);
      chk("t4_done_cycle", done_cyc, t0 + 5);
      chk("t4_ren_count", ren_cnt, 3);
      chk("t4_left_addr", addr_q.size(), 0);

      // 5: reset in the middle of a dump
      $display("T5: reset after 4 of 8 words");
      clear_stats();
      issue(32'h0, 8, 1'b0);
      for (int i = 0; i < 50 && hs_cnt < 4; i++) @(negedge clk);
      chk("t5_reached_4", {31'b0, (hs_cnt >= 4)}, 32'h1);
      #2 arst_n = 1'b0;
      #1 check_all_zero("midreset");
      exp_q.delete();
      addr_q.delete();
      @(posedge clk);
      @(posedge clk);
      #3 arst_n = 1'b1;
      clear_stats();
      issue(32'h0, 2, 1'b1);
      wait_done(50);
      chk("t5_done_cycle", done_cyc, t0 + 4);
      chk("t5_words", hs_cnt, 2);
      chk("t5_ren_count", ren_cnt, 2);

      // 6: checksum of words 1, 2, 4
      $display("T6: checksum of 1,2,4");
      dmem[0] = 32'h1;
      dmem[1] = 32'h2;
      dmem[2] = 32'h4;
      clear_stats();
      issue(32'h0, 3, 1'b1);
      wait_done(50);
`ifdef MEM_READBACK_CHECKSUM_EN
      exp_ck = 32'h0000_0004;
`else
      exp_ck = 32'h0;
`endif
      chk("t6_checksum_at_done", done_ck, exp_ck);
      chk("t6_checksum_after", checksum, exp_ck);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
